piso_serializer: RTL
====================

# piso_serializer

Parallel-in/serial-out stage that takes the parallel words produced by the 4-bit parallel register stage and serialises them for a single-wire link. A valid/ready handshake controls word acceptance. A one-word holding buffer lets a new word be accepted while the current one is shifting out, so consecutive words leave with no idle cycle between them.

## Interface
- WIDTH, 4, bits per word; legal values are WIDTH ≥ 2.
- MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first, 0 = shift out bit 0 first.

- in_clk  input  1  clock; all state changes on the rising edge.
- in_rst  input  1  asynchronous, active-high reset.
- in_l  input  WIDTH  parallel word to serialise.
- in_valid  input  1  in_l holds a valid word.
- o_ready  output  1  block can accept a word this cycle.
- o_ser  output  1  serial data bit.
- o_ser_valid  output  1  o_ser carries a valid bit.
- o_last  output  1  o_ser is the final bit of the current word.
- o_busy  output  1  a word is shifting, or a word is waiting in the holding buffer.

## Operation
- Internal state:
  - shift register sh[WIDTH-1:0]
  - bit counter cnt, width clog2(WIDTH)
  - holding register hold[WIDTH-1:0] and flag hold_full
  - FSM with states IDLE and SHIFT
- Accept condition: in_valid && o_ready, sampled on the rising edge. in_l is ignored when o_ready = 0.
- o_ready = !hold_full. It is a direct decode of a register, with no combinational path from in_valid.
- Output decode (combinational from registers):
  - o_ser_valid = (state == SHIFT).
  - o_ser = sh[WIDTH-1] if MSB_FIRST, otherwise sh[0]. o_ser is forced to 0 when o_ser_valid = 0.
  - o_last = (state == SHIFT) && (cnt == WIDTH-1).
  - o_busy = (state == SHIFT) || hold_full.
- IDLE:
  - On accept: sh ← in_l, cnt ← 0, go to SHIFT.
  - Otherwise: stay in IDLE.
- SHIFT, when cnt < WIDTH-1:
  - Shift sh by one, towards the MSB if MSB_FIRST, otherwise towards the LSB; zero-fill. Then cnt ← cnt + 1.
  - On accept: hold ← in_l, hold_full ← 1.
- SHIFT, when cnt == WIDTH-1 (last bit):
  - If hold_full: sh ← hold, hold_full ← 0, cnt ← 0, stay in SHIFT. No accept is possible, because o_ready = 0.
  - Else if accept: sh ← in_l, cnt ← 0, stay in SHIFT. The word bypasses the holding buffer.
  - Else: go to IDLE, cnt ← 0, sh ← 0.
- Boundary conditions:
  - At most two words are in flight: one shifting, one held.
  - A third word is back-pressured through o_ready = 0 until the held word moves into sh.
- Reset (asynchronous, any cycle, including mid-word):
  - State: state = IDLE, sh = 0, cnt = 0, hold = 0, hold_full = 0.
  - Outputs: o_ready = 1, o_ser = 0, o_ser_valid = 0, o_last = 0, o_busy = 0.
  - A partially sent word and any held word are discarded. No bits are emitted after reset is asserted.

## Timing
- Latency: a word accepted at edge k puts its first bit on o_ser in the cycle after edge k. Bit j appears in the cycle after edge k+j, for j = 0..WIDTH-1.
- A word occupies exactly WIDTH consecutive o_ser_valid cycles. o_last is high only in the final one.
- Throughput: one bit per cycle. With the holding buffer pre-filled, or with an accept on the o_last cycle, back-to-back words have zero gap cycles.
- o_ready falls in the cycle after a hold accept. It rises in the cycle after the held word is loaded into sh.
- Reset takes effect immediately, without waiting for in_clk. Release of in_rst must be at least 1 ns away from a rising edge of in_clk.

## Test plan
- **Reset:** assert in_rst mid-simulation.
  - Required: o_ready = 1, o_ser = 0, o_ser_valid = 0, o_last = 0, o_busy = 0 immediately, before any clock edge.
- **Single word:** WIDTH = 4, MSB_FIRST = 1; accept 4'b1011 once.
  - Required: o_ser = 1, 0, 1, 1 on cycles 1–4, o_ser_valid high for exactly those 4 cycles, o_last high on cycle 4 only.
  - Then: o_busy drops and o_ser_valid = 0 on cycle 5.
- **Back-to-back:** hold in_valid high with 4'b1100, 4'b0011, 4'b1111 presented as o_ready allows.
  - Required: 12 consecutive valid bits 1100_0011_1111, with o_last on bits 4, 8 and 12.
- **Backpressure:** accept 4'b1010, then accept 4'b0101 on the next cycle, then keep in_valid high with 4'b1110.
  - Required: o_ready = 0 until the first word's o_last edge. 4'b1110 is not accepted before that, and the output order is 1010, 0101, 1110.
- **Reset mid-word:** accept 4'b1111 with a word held; assert in_rst after 2 bits.
  - Required: o_ser_valid = 0 immediately, and no remaining bits of either word appear after release.
  - Then: the next accepted word, 4'b1001, serialises correctly.
- **LSB-first:** MSB_FIRST = 0, accept 4'b1011.
  - Required: o_ser = 1, 1, 0, 1.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with a valid/ready input and a one-word holding buffer,
// so a word queued during shifting follows the current word with no idle cycle.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             in_clk,
    input  logic             in_rst,
    input  logic [WIDTH-1:0] in_l,
    input  logic             in_valid,
    output logic             o_ready,
    output logic             o_ser,
    output logic             o_ser_valid,
    output logic             o_last,
    output logic             o_busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             accept;
    logic [WIDTH-1:0] sh_next;

    assign accept = in_valid && !hold_full_q;

    // The outgoing bit always sits at the end that o_ser taps.
    assign sh_next = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d    = in_l;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != LAST) begin
                    sh_d  = sh_next;
                    cnt_d = cnt_q + CW'(1);
                    if (accept) begin
                        hold_d      = in_l;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    sh_d        = hold_q;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                end else if (accept) begin
                    // Word arriving on the final bit skips the holding buffer.
                    sh_d  = in_l;
                    cnt_d = '0;
                end else begin
                    sh_d    = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

    assign o_ready     = !hold_full_q;
    assign o_ser_valid = (state_q == SHIFT);
    assign o_ser       = o_ser_valid && (MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0]);
    assign o_last      = (state_q == SHIFT) && (cnt_q == LAST);
    assign o_busy      = (state_q == SHIFT) || hold_full_q;

endmodule
